// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader.
// Consumes a byte stream: 16-bit little-endian word count, then that many
// little-endian 32-bit instructions, each written to the instruction memory.
// The CPU is held off while a load is in flight or after a rejected header.
module inst_mem_loader #(
    parameter int INST_MEM_SIZE = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERROR} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(INST_MEM_SIZE);

    state_t           state;
    logic [7:0]       n_lo;       // low header byte, held until HDR1
    logic [CNT_W-1:0] n_words;    // decoded word count for this session
    logic [CNT_W-1:0] k;          // index of the word being assembled
    logic [1:0]       b;          // byte position within the current word
    logic [23:0]      asm_buf;    // first three bytes of the current word
    logic             xfer;
    logic [CNT_W-1:0] hdr;

    assign xfer = rx_valid && rx_ready;
    assign hdr  = CNT_W'({rx_data, n_lo});

    // Handshake and status are pure decodes of the state plus the write strobe.
    always_comb begin
        busy     = (state == HDR0) || (state == HDR1) || (state == DATA);
        rx_ready = busy;
        cpu_hold = busy || wr_en || (state == ERROR);
    end

    // Session FSM: header decode, word assembly and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            n_lo     <= '0;
            n_words  <= '0;
            k        <= '0;
            b        <= '0;
            asm_buf  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= HDR0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= '0;
                        k        <= '0;
                        b        <= '0;
                    end
                end
                HDR0: begin
                    if (xfer) begin
                        n_lo  <= rx_data;
                        state <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        n_words <= hdr;
                        if (hdr == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (hdr > LIMIT) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        b <= b + 2'd1;
                        case (b)
                            2'd0: asm_buf[7:0]   <= rx_data;
                            2'd1: asm_buf[15:8]  <= rx_data;
                            2'd2: asm_buf[23:16] <= rx_data;
                            default: begin
                                // Fourth byte completes the word: issue the write.
                                wr_en    <= 1'b1;
                                wr_data  <= {rx_data, asm_buf};
                                wr_addr  <= 32'(k) << 2;
                                word_cnt <= k + 1'b1;
                                k        <= k + 1'b1;
                                if (k == n_words - 1'b1) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
